ntt_layer_sequencer: RTL and testbench

Sequencer for the Kyber NTT/INTT datapath. It walks all 7 layers of a 256-coefficient in-place transform through a single `Butterfly_unit` pipeline. Each cycle it issues one butterfly pair's read addresses and zeta index to the coefficient RAM and zeta ROM. It then delays those addresses to match the read and butterfly latency and generates the write-back. It sits between the top-level NTT controller (start/done) and the RAM/ROM/butterfly datapath.

---
 rtl/ntt_layer_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_ntt_layer_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_layer_sequencer.sv
// Address/zeta sequencer walking 7 NTT/INTT layers through one butterfly pipeline, with delayed write-back.
// Optional valid-alignment checker is built only when NTT_SEQ_CHECK_EN is defined.
module ntt_layer_sequencer #(
    parameter int BF_LAT = 3,
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       r,
    input  logic       start,
    input  logic       inverse_in,
    output logic       rd_en,
    output logic [7:0] rd_addr_a,
    output logic [7:0] rd_addr_b,
    output logic [6:0] zeta_idx,
    output logic       bf_valid,
    output logic       bf_inverse,
    input  logic       bf_valid_out,
    output logic       wr_en,
    output logic [7:0] wr_addr_a,
    output logic [7:0] wr_addr_b,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int D = RD_LAT + BF_LAT;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t     state_q;
    logic [2:0] layer_q, layer_d;
    logic [6:0] cnt_q, cnt_d;
    logic       inv_q, inv_d;
    logic [7:0] drain_q;
    logic       rd_en_q;
    logic [7:0] rd_a_q, rd_b_q;
    logic [6:0] zeta_q;
    logic       busy_q, done_q;

    logic [7:0] a_d, b_d;
    logic [6:0] z_d;
    logic [2:0] eff;
    logic [3:0] s;
    logic [7:0] p, grp, lowmask;
    logic [6:0] grp7;

    // Pair that will be presented on the read port after the next edge.
    always_comb begin
        layer_d = layer_q;
        cnt_d   = 7'd0;
        inv_d   = inv_q;
        case (state_q)
            S_IDLE: begin
                layer_d = 3'd0;
                inv_d   = inverse_in;
            end
            S_ISSUE: cnt_d   = cnt_q + 7'd1;
            S_DRAIN: layer_d = layer_q + 3'd1;
            default: ;
        endcase
    end

    always_comb begin
        eff     = inv_d ? (3'd6 - layer_d) : layer_d;
        s       = 4'd7 - {1'b0, eff};
        p       = {1'b0, cnt_d};
        lowmask = (8'd1 << s) - 8'd1;
        grp     = p >> s;
        grp7    = cnt_d >> s;
        a_d     = ((grp << 1) << s) | (p & lowmask);
        b_d     = a_d | (8'd1 << s);
        // 7-bit wrap makes 2^(L+1)-1-g correct even for L=6.
        z_d     = inv_d ? ((7'd2 << eff) - 7'd1 - grp7) : ((7'd1 << eff) + grp7);
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q <= S_IDLE;
            layer_q <= 3'd0;
            cnt_q   <= 7'd0;
            inv_q   <= 1'b0;
            drain_q <= 8'd0;
            rd_en_q <= 1'b0;
            rd_a_q  <= 8'd0;
            rd_b_q  <= 8'd0;
            zeta_q  <= 7'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ISSUE;
                        layer_q <= layer_d;
                        cnt_q   <= cnt_d;
                        inv_q   <= inv_d;
                        rd_en_q <= 1'b1;
                        rd_a_q  <= a_d;
                        rd_b_q  <= b_d;
                        zeta_q  <= z_d;
                        busy_q  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (cnt_q == 7'd127) begin
                        state_q <= S_DRAIN;
                        rd_en_q <= 1'b0;
                        drain_q <= 8'd0;
                    end else begin
                        cnt_q  <= cnt_d;
                        rd_a_q <= a_d;
                        rd_b_q <= b_d;
                        zeta_q <= z_d;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == 8'(D - 1)) begin
                        if (layer_q == 3'd6) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            layer_q <= layer_d;
                            cnt_q   <= cnt_d;
                            rd_en_q <= 1'b1;
                            rd_a_q  <= a_d;
                            rd_b_q  <= b_d;
                            zeta_q  <= z_d;
                        end
                    end else begin
                        drain_q <= drain_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic [D-1:0] vld_pipe_q;
    logic [7:0]   wa_pipe_q [D];
    logic [7:0]   wb_pipe_q [D];

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            vld_pipe_q <= '0;
            for (int i = 0; i < D; i++) begin
                wa_pipe_q[i] <= 8'd0;
                wb_pipe_q[i] <= 8'd0;
            end
        end else begin
            vld_pipe_q[0] <= rd_en_q;
            wa_pipe_q[0]  <= rd_a_q;
            wb_pipe_q[0]  <= rd_b_q;
            for (int i = 1; i < D; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                wa_pipe_q[i]  <= wa_pipe_q[i-1];
                wb_pipe_q[i]  <= wb_pipe_q[i-1];
            end
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr_a  = rd_a_q;
    assign rd_addr_b  = rd_b_q;
    assign zeta_idx   = zeta_q;
    assign bf_valid   = vld_pipe_q[RD_LAT-1];
    assign bf_inverse = inv_q;
    assign wr_en      = vld_pipe_q[D-1];
    assign wr_addr_a  = wa_pipe_q[D-1];
    assign wr_addr_b  = wb_pipe_q[D-1];
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef NTT_SEQ_CHECK_EN
    logic err_q;

    // The write-back valid is exactly bf_valid delayed by BF_LAT.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            err_q <= 1'b0;
        end else if (bf_valid_out != vld_pipe_q[D-1]) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_bf_valid_out;
    assign unused_bf_valid_out = bf_valid_out;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_layer_sequencer.sv
// Directed bench for ntt_layer_sequencer: per-cycle capture of a full run, then hand-derived checks.
module tb_ntt_layer_sequencer;

    localparam int NREC = 930;

    logic       clk = 1'b0;
    logic       r = 1'b1;
    logic       start = 1'b0;
    logic       inverse_in = 1'b0;
    logic       bf_valid_out;
    logic       rd_en, bf_valid, bf_inverse, wr_en, busy, done, err;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] zeta_idx;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] vpipe;
    logic       kill = 1'b0;

    logic       rec_rd_en [0:NREC+1];
    logic [7:0] rec_a     [0:NREC+1];
    logic [7:0] rec_b     [0:NREC+1];
    logic [6:0] rec_z     [0:NREC+1];
    logic       rec_bfv   [0:NREC+1];
    logic       rec_bfi   [0:NREC+1];
    logic       rec_wr_en [0:NREC+1];
    logic [7:0] rec_wa    [0:NREC+1];
    logic [7:0] rec_wb    [0:NREC+1];
    logic       rec_done  [0:NREC+1];
    logic       rec_busy  [0:NREC+1];

    ntt_layer_sequencer #(.BF_LAT(3), .RD_LAT(1)) dut (
        .clk(clk), .r(r), .start(start), .inverse_in(inverse_in),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .zeta_idx(zeta_idx),
        .bf_valid(bf_valid), .bf_inverse(bf_inverse), .bf_valid_out(bf_valid_out),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Stand-in butterfly: valid_out is valid_in three cycles later.
    always @(posedge clk or posedge r) begin
        if (r) vpipe <= 3'b000;
        else   vpipe <= {vpipe[1:0], bf_valid};
    end
    assign bf_valid_out = vpipe[2] & ~kill;

    task automatic run_capture(input logic inv, input int poke_at);
        @(negedge clk);
        inverse_in = inv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        inverse_in = 1'b0;
        for (int c = 1; c <= NREC; c++) begin
            rec_rd_en[c] = rd_en;  rec_a[c] = rd_addr_a;  rec_b[c] = rd_addr_b;
            rec_z[c] = zeta_idx;   rec_bfv[c] = bf_valid; rec_bfi[c] = bf_inverse;
            rec_wr_en[c] = wr_en;  rec_wa[c] = wr_addr_a; rec_wb[c] = wr_addr_b;
            rec_done[c] = done;    rec_busy[c] = busy;
            start = (c == poke_at);
            inverse_in = (c == poke_at) ? ~inv : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        inverse_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [47:0] outs;
        int bad;
        repeat (3) @(negedge clk);
        outs = {rd_en, rd_addr_a, rd_addr_b, zeta_idx, bf_valid, bf_inverse, wr_en,
                wr_addr_a, wr_addr_b, busy, done, err};
        n_cmp++;
        if (outs !== 48'd0) begin n_err++; $display("FAIL reset_outputs got %h want 0", outs); end
        r = 1'b0;
        @(negedge clk);
        inverse_in = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        inverse_in = 1'b0;
        repeat (49) @(negedge clk);
        n_cmp++;
        if (wr_en !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL midrun_active got wr_en=%b busy=%b want 1 1", wr_en, busy);
        end
        r = 1'b1;
        #1;
        outs = {rd_en, rd_addr_a, rd_addr_b, zeta_idx, bf_valid, bf_inverse, wr_en,
                wr_addr_a, wr_addr_b, busy, done, err};
        n_cmp++;
        if (outs !== 48'd0) begin n_err++; $display("FAIL async_reset_outputs got %h want 0", outs); end
        @(negedge clk);
        r = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL post_reset_quiet got %0d active cycles want 0", bad); end
        run_capture(1'b0, 0);
        n_cmp++;
        if (rec_done[925] !== 1'b1 || rec_busy[926] !== 1'b0) begin
            n_err++; $display("FAIL post_reset_run got done925=%b busy926=%b want 1 0", rec_done[925], rec_busy[926]);
        end
    endtask

    task automatic test_ntt_sweep();
        int bad;
        int cnt_w [256];
        run_capture(1'b0, 0);
        n_cmp++;
        if ({rec_rd_en[1], rec_a[1], rec_b[1], rec_z[1]} !== {1'b1, 8'd0, 8'd128, 7'd1}) begin
            n_err++; $display("FAIL ntt_l0_c0 got en=%b a=%0d b=%0d z=%0d want 1 0 128 1", rec_rd_en[1], rec_a[1], rec_b[1], rec_z[1]);
        end
        n_cmp++;
        if ({rec_a[128], rec_b[128]} !== {8'd127, 8'd255}) begin
            n_err++; $display("FAIL ntt_l0_c127 got a=%0d b=%0d want 127 255", rec_a[128], rec_b[128]);
        end
        n_cmp++;
        if ({rec_a[793], rec_b[793], rec_z[793]} !== {8'd0, 8'd2, 7'd64}) begin
            n_err++; $display("FAIL ntt_l6_c0 got a=%0d b=%0d z=%0d want 0 2 64", rec_a[793], rec_b[793], rec_z[793]);
        end
        n_cmp++;
        if ({rec_a[794], rec_b[794], rec_z[794]} !== {8'd1, 8'd3, 7'd64}) begin
            n_err++; $display("FAIL ntt_l6_c1 got a=%0d b=%0d z=%0d want 1 3 64", rec_a[794], rec_b[794], rec_z[794]);
        end
        n_cmp++;
        if ({rec_a[795], rec_b[795], rec_z[795]} !== {8'd4, 8'd6, 7'd65}) begin
            n_err++; $display("FAIL ntt_l6_c2 got a=%0d b=%0d z=%0d want 4 6 65", rec_a[795], rec_b[795], rec_z[795]);
        end
        n_cmp++;
        if ({rec_a[920], rec_b[920], rec_z[920]} !== {8'd253, 8'd255, 7'd127}) begin
            n_err++; $display("FAIL ntt_l6_c127 got a=%0d b=%0d z=%0d want 253 255 127", rec_a[920], rec_b[920], rec_z[920]);
        end
        for (int l = 0; l < 7; l++) begin
            foreach (cnt_w[i]) cnt_w[i] = 0;
            for (int c = l * 132 + 1; c <= l * 132 + 132; c++) begin
                if (rec_wr_en[c] === 1'b1) begin
                    cnt_w[rec_wa[c]]++;
                    cnt_w[rec_wb[c]]++;
                    if (rec_wb[c] - rec_wa[c] !== (9'd128 >> l)) cnt_w[0] += 100;
                end
            end
            bad = 0;
            foreach (cnt_w[i]) if (cnt_w[i] != 1) bad++;
            n_cmp++;
            if (bad !== 0) begin n_err++; $display("FAIL ntt_layer%0d_write_cover got %0d bad addresses want 0", l, bad); end
        end
    endtask

    task automatic test_intt_sweep();
        int bad;
        run_capture(1'b1, 0);
        n_cmp++;
        if ({rec_a[1], rec_b[1], rec_z[1]} !== {8'd0, 8'd2, 7'd127}) begin
            n_err++; $display("FAIL intt_l0_c0 got a=%0d b=%0d z=%0d want 0 2 127", rec_a[1], rec_b[1], rec_z[1]);
        end
        n_cmp++;
        if ({rec_a[3], rec_b[3], rec_z[3]} !== {8'd4, 8'd6, 7'd126}) begin
            n_err++; $display("FAIL intt_l0_c2 got a=%0d b=%0d z=%0d want 4 6 126", rec_a[3], rec_b[3], rec_z[3]);
        end
        n_cmp++;
        if ({rec_a[793], rec_b[793], rec_z[793]} !== {8'd0, 8'd128, 7'd1}) begin
            n_err++; $display("FAIL intt_l6_c0 got a=%0d b=%0d z=%0d want 0 128 1", rec_a[793], rec_b[793], rec_z[793]);
        end
        bad = 0;
        for (int c = 1; c <= 925; c++) if (rec_bfi[c] !== 1'b1) bad++;
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL intt_bf_inverse got %0d low cycles want 0", bad); end
    endtask

    task automatic test_timing();
        int bad;
        int ndone;
        run_capture(1'b0, 100);
        bad = 0;
        for (int c = 1; c <= 925; c++) begin
            if (rec_rd_en[c] === 1'b1) begin
                if (rec_wr_en[c+4] !== 1'b1 || rec_wa[c+4] !== rec_a[c] || rec_wb[c+4] !== rec_b[c]) bad++;
            end
        end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL wr_delay4 got %0d bad reads want 0", bad); end
        bad = 0;
        for (int c = 1; c < NREC; c++) if (rec_bfv[c+1] !== rec_rd_en[c]) bad++;
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL bf_valid_delay1 got %0d bad cycles want 0", bad); end
        bad = 0;
        for (int l = 0; l < 6; l++) begin
            for (int c = l * 132 + 129; c <= l * 132 + 132; c++) if (rec_rd_en[c] !== 1'b0) bad++;
            if (rec_rd_en[l * 132 + 133] !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL layer_gap got %0d bad cycles want 0", bad); end
        ndone = 0;
        for (int c = 1; c <= NREC; c++) if (rec_done[c] === 1'b1) ndone++;
        n_cmp++;
        if (rec_done[925] !== 1'b1 || ndone !== 1) begin
            n_err++; $display("FAIL done_cycle got done925=%b pulses=%0d want 1 1", rec_done[925], ndone);
        end
        n_cmp++;
        if ({rec_busy[1], rec_busy[925], rec_busy[926]} !== 3'b110) begin
            n_err++; $display("FAIL busy_window got %b want 110", {rec_busy[1], rec_busy[925], rec_busy[926]});
        end
        bad = 0;
        for (int c = 1; c <= 925; c++) if (rec_bfi[c] !== 1'b0) bad++;
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL busy_start_ignored got %0d inverse cycles want 0", bad); end
    endtask

    task automatic test_back_to_back();
        int k;
        run_capture(1'b0, 926);
        n_cmp++;
        if ({rec_rd_en[927], rec_bfi[927], rec_a[927], rec_b[927], rec_z[927]} !== {1'b1, 1'b1, 8'd0, 8'd2, 7'd127}) begin
            n_err++; $display("FAIL b2b_restart got en=%b inv=%b a=%0d b=%0d z=%0d want 1 1 0 2 127",
                rec_rd_en[927], rec_bfi[927], rec_a[927], rec_b[927], rec_z[927]);
        end
        k = 931;
        while (done !== 1'b1 && k < 2100) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k !== 1851) begin n_err++; $display("FAIL b2b_done_cycle got %0d want 1851", k); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_checker();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        n_cmp++;
        if (wr_en !== 1'b1 || err !== 1'b0) begin
            n_err++; $display("FAIL chk_pre got wr_en=%b err=%b want 1 0", wr_en, err);
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        repeat (5) @(negedge clk);
`ifdef NTT_SEQ_CHECK_EN
        n_cmp++;
        if (err !== 1'b1) begin n_err++; $display("FAIL chk_err_set got %b want 1", err); end
        repeat (50) @(negedge clk);
        n_cmp++;
        if (err !== 1'b1) begin n_err++; $display("FAIL chk_err_sticky got %b want 1", err); end
`else
        n_cmp++;
        if (err !== 1'b0) begin n_err++; $display("FAIL chk_err_tied got %b want 0", err); end
`endif
        r = 1'b1;
        @(negedge clk);
        r = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL chk_err_cleared got err=%b busy=%b want 0 0", err, busy);
        end
    endtask

    initial begin
        test_reset();
        test_ntt_sweep();
        test_intt_sweep();
        test_timing();
        test_back_to_back();
        test_checker();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
